// File: rtl/wisc_pkg.sv
// Shared definitions for the memory stage: opcodes, FSM states and the data word type.
package wisc_pkg;

    typedef logic [15:0] word_t;

    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating wait-cycle counter for the memory stage.
// The hit flags are raised in the wait cycle whose closing edge brings the
// count up to the limit, so the FSM can leave its wait state on that edge.
module mem_wait_counter #(
    parameter int MEM_LATENCY = 4,
    parameter int TIMEOUT     = 16,
    parameter int CW          = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic latency_hit,
    output logic timeout_hit
);

    logic [CW-1:0] count;

    // Count wait cycles, clearing on request and holding at TIMEOUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign latency_hit = (count == CW'(MEM_LATENCY - 1));
    assign timeout_hit = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: registers ALU results, issues one request per
// LW/SW to a multi-cycle memory, stalls upstream while an access is in
// flight and emits a one-cycle write-back record on completion.
module mem_access_ctrl
    import wisc_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_store_data,
    input  logic [3:0]  ex_dst_reg,
    input  logic        ex_wr_en,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_dst_reg,
    output logic        wb_wr_en,
    output logic        err_timeout
);

    mem_state_t state;
    logic [3:0] lat_dst;
    logic       lat_wr_en;
    logic       latency_hit;
    logic       timeout_hit;

    mem_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY),
        .TIMEOUT    (TIMEOUT)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .enable     (state != IDLE),
        .latency_hit(latency_hit),
        .timeout_hit(timeout_hit)
    );

    assign stall = (state != IDLE);

    // Access FSM with all outputs registered; strobes default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lat_dst     <= '0;
            lat_wr_en   <= 1'b0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_dst_reg  <= '0;
            wb_wr_en    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (ex_opcode == OP_LW) begin
                            state     <= RD_WAIT;
                            mem_en    <= 1'b1;
                            mem_wr    <= 1'b0;
                            mem_addr  <= {ex_alu_out[15:1], 1'b0};
                            lat_dst   <= ex_dst_reg;
                            lat_wr_en <= ex_wr_en;
                        end else if (ex_opcode == OP_SW) begin
                            state     <= WR_WAIT;
                            mem_en    <= 1'b1;
                            mem_wr    <= 1'b1;
                            mem_addr  <= {ex_alu_out[15:1], 1'b0};
                            mem_wdata <= ex_store_data;
                            lat_dst   <= ex_dst_reg;
                            lat_wr_en <= 1'b0;
                        end else begin
                            wb_valid   <= 1'b1;
                            wb_data    <= ex_alu_out;
                            wb_dst_reg <= ex_dst_reg;
                            wb_wr_en   <= ex_wr_en;
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_data_valid) begin
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_data    <= mem_rdata;
                        wb_dst_reg <= lat_dst;
                        wb_wr_en   <= lat_wr_en;
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (latency_hit) begin
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_dst_reg <= lat_dst;
                        wb_wr_en   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (MEM_LATENCY=4, TIMEOUT=16).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_dst_reg;
    logic        ex_wr_en;
    logic        stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [3:0]  wb_dst_reg;
    logic        wb_wr_en;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(
        .MEM_LATENCY(4),
        .TIMEOUT    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_alu_out    (ex_alu_out),
        .ex_store_data (ex_store_data),
        .ex_dst_reg    (ex_dst_reg),
        .ex_wr_en      (ex_wr_en),
        .stall         (stall),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_data_valid(mem_data_valid),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_dst_reg    (wb_dst_reg),
        .wb_wr_en      (wb_wr_en),
        .err_timeout   (err_timeout)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [15:0] alu,
                                 input logic [15:0] sdata, input logic [3:0] dst, input logic we);
        ex_valid      = v;
        ex_opcode     = op;
        ex_alu_out    = alu;
        ex_store_data = sdata;
        ex_dst_reg    = dst;
        ex_wr_en      = we;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        mem_rdata      = '0;
        mem_data_valid = 1'b0;
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
        step();
        step();

        $display("[TB] reset state");
        checkOutput("rst_stall", {15'd0, stall}, 16'd0);
        checkOutput("rst_mem_en", {15'd0, mem_en}, 16'd0);
        checkOutput("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        checkOutput("rst_err", {15'd0, err_timeout}, 16'd0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        step();

        $display("[TB] non-memory op");
        applyStimulus(1'b1, 4'b0000, 16'h1234, 16'h0, 4'd5, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        checkOutput("alu_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("alu_wb_data", wb_data, 16'h1234);
        checkOutput("alu_wb_dst", {12'd0, wb_dst_reg}, 16'd5);
        checkOutput("alu_wb_wr_en", {15'd0, wb_wr_en}, 16'd1);
        checkOutput("alu_stall", {15'd0, stall}, 16'd0);

        $display("[TB] load with 3-cycle stall");
        applyStimulus(1'b1, 4'b1000, 16'h0041, 16'h0, 4'd7, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        checkOutput("lw_mem_en_c1", {15'd0, mem_en}, 16'd1);
        checkOutput("lw_mem_wr", {15'd0, mem_wr}, 16'd0);
        checkOutput("lw_mem_addr", mem_addr, 16'h0040);
        checkOutput("lw_stall_c1", {15'd0, stall}, 16'd1);
        step();
        checkOutput("lw_mem_en_c2", {15'd0, mem_en}, 16'd0);
        checkOutput("lw_stall_c2", {15'd0, stall}, 16'd1);
        step();
        checkOutput("lw_stall_c3", {15'd0, stall}, 16'd1);
        checkOutput("lw_wb_valid_c3", {15'd0, wb_valid}, 16'd0);
        mem_rdata      = 16'hBEEF;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        checkOutput("lw_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("lw_wb_data", wb_data, 16'hBEEF);
        checkOutput("lw_wb_dst", {12'd0, wb_dst_reg}, 16'd7);
        checkOutput("lw_stall_done", {15'd0, stall}, 16'd0);
        step();
        checkOutput("lw_wb_pulse", {15'd0, wb_valid}, 16'd0);

        $display("[TB] store with ignored ex_valid during stall");
        applyStimulus(1'b1, 4'b1001, 16'h0010, 16'hA5A5, 4'd3, 1'b1);
        step();
        applyStimulus(1'b1, 4'b0000, 16'h9999, 16'h0, 4'd9, 1'b1);
        checkOutput("sw_mem_en", {15'd0, mem_en}, 16'd1);
        checkOutput("sw_mem_wr", {15'd0, mem_wr}, 16'd1);
        checkOutput("sw_mem_addr", mem_addr, 16'h0010);
        checkOutput("sw_mem_wdata", mem_wdata, 16'hA5A5);
        checkOutput("sw_stall_c1", {15'd0, stall}, 16'd1);
        step();
        checkOutput("sw_mem_en_c2", {15'd0, mem_en}, 16'd0);
        checkOutput("sw_stall_c2", {15'd0, stall}, 16'd1);
        checkOutput("sw_wb_c2", {15'd0, wb_valid}, 16'd0);
        step();
        checkOutput("sw_stall_c3", {15'd0, stall}, 16'd1);
        checkOutput("sw_wb_c3", {15'd0, wb_valid}, 16'd0);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        checkOutput("sw_stall_c4", {15'd0, stall}, 16'd1);
        checkOutput("sw_wb_c4", {15'd0, wb_valid}, 16'd0);
        step();
        checkOutput("sw_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("sw_wb_wr_en", {15'd0, wb_wr_en}, 16'd0);
        checkOutput("sw_stall_done", {15'd0, stall}, 16'd0);
        step();
        checkOutput("sw_wb_pulse", {15'd0, wb_valid}, 16'd0);

        $display("[TB] load data on the last allowed cycle");
        applyStimulus(1'b1, 4'b1000, 16'h0080, 16'h0, 4'd4, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        repeat (15) step();
        checkOutput("edge_stall_c16", {15'd0, stall}, 16'd1);
        mem_rdata      = 16'hCAFE;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        checkOutput("edge_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("edge_wb_data", wb_data, 16'hCAFE);
        checkOutput("edge_err", {15'd0, err_timeout}, 16'd0);

        $display("[TB] load timeout");
        applyStimulus(1'b1, 4'b1000, 16'h0100, 16'h0, 4'd2, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        repeat (15) step();
        checkOutput("to_stall_c16", {15'd0, stall}, 16'd1);
        checkOutput("to_err_c16", {15'd0, err_timeout}, 16'd0);
        step();
        checkOutput("to_err", {15'd0, err_timeout}, 16'd1);
        checkOutput("to_stall", {15'd0, stall}, 16'd0);
        checkOutput("to_no_wb", {15'd0, wb_valid}, 16'd0);
        applyStimulus(1'b1, 4'b0000, 16'h0055, 16'h0, 4'd1, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        checkOutput("to_next_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("to_next_wb_data", wb_data, 16'h0055);
        checkOutput("to_err_sticky", {15'd0, err_timeout}, 16'd1);

        $display("[TB] reset during load wait");
        applyStimulus(1'b1, 4'b1000, 16'h0200, 16'h0, 4'd6, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_stall", {15'd0, stall}, 16'd0);
        checkOutput("mid_rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("mid_rst_wb_data", wb_data, 16'h0000);
        checkOutput("mid_rst_err", {15'd0, err_timeout}, 16'd0);
        step();
        rst            = 1'b0;
        mem_rdata      = 16'h1111;
        mem_data_valid = 1'b1;
        step();
        checkOutput("late_data_wb1", {15'd0, wb_valid}, 16'd0);
        checkOutput("late_data_stall", {15'd0, stall}, 16'd0);
        mem_data_valid = 1'b0;
        step();
        checkOutput("late_data_wb2", {15'd0, wb_valid}, 16'd0);
        checkOutput("late_data_wb_data", wb_data, 16'h0000);

        $display("[TB] ADD/LW/ADD back-to-back");
        applyStimulus(1'b1, 4'b0000, 16'h0011, 16'h0, 4'd1, 1'b1);
        step();
        checkOutput("seq_add1_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("seq_add1_data", wb_data, 16'h0011);
        applyStimulus(1'b1, 4'b1000, 16'h0300, 16'h0, 4'd2, 1'b1);
        step();
        checkOutput("seq_lw_req", {15'd0, mem_en}, 16'd1);
        checkOutput("seq_lw_nowb", {15'd0, wb_valid}, 16'd0);
        applyStimulus(1'b1, 4'b0000, 16'h0033, 16'h0, 4'd3, 1'b1);
        mem_rdata      = 16'h4444;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        checkOutput("seq_lw_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("seq_lw_data", wb_data, 16'h4444);
        checkOutput("seq_lw_dst", {12'd0, wb_dst_reg}, 16'd2);
        step();
        applyStimulus(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0, 1'b0);
        checkOutput("seq_add2_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("seq_add2_data", wb_data, 16'h0033);
        checkOutput("seq_add2_dst", {12'd0, wb_dst_reg}, 16'd3);
        step();
        checkOutput("seq_idle", {15'd0, wb_valid}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage controller sitting directly downstream of the ALU. It registers each executed instruction's ALU result and turns LW/SW into a single request to a multi-cycle data memory. It stalls the upstream pipeline while a memory access is outstanding and presents a write-back record (data, destination, enable) one cycle after completion. Non-memory ops pass straight through with one cycle of latency.

## Interface
- MEM_LATENCY, 4: cycles a store occupies memory after its request cycle (1..15)
- TIMEOUT, 16: max cycles to wait for load data after the request cycle (> MEM_LATENCY)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  instruction presented by the ALU stage
- ex_opcode  in  4  instruction opcode (LW=4'b1000, SW=4'b1001)
- ex_alu_out  in  16  ALU result; the effective address for LW/SW
- ex_store_data  in  16  store data (SW)
- ex_dst_reg  in  4  destination register
- ex_wr_en  in  1  instruction writes the register file
- stall  out  1  upstream must hold ex_* and not advance
- mem_en  out  1  one-cycle memory request strobe
- mem_wr  out  1  request is a write (valid with mem_en)
- mem_addr  out  16  request address, bit 0 forced 0
- mem_wdata  out  16  store data
- mem_rdata  in  16  load data
- mem_data_valid  in  1  mem_rdata valid this cycle
- wb_valid  out  1  write-back record valid (one-cycle pulse)
- wb_data  out  16  write-back value
- wb_dst_reg  out  4  write-back register
- wb_wr_en  out  1  register-file write enable (0 for SW)
- err_timeout  out  1  sticky load-timeout flag

## Operation
- States: IDLE, RD_WAIT, WR_WAIT. stall = (state != IDLE), decoded from the state register.
- In IDLE, ex_valid=1 is accepted at the clock edge. While stall=1, ex_valid is ignored.
- On accept of a non-memory op: wb_valid=1, wb_data=ex_alu_out, wb_dst_reg/wb_wr_en copied. State stays IDLE.
- On accept of LW: latch addr, dst, wr_en, then go to RD_WAIT.
  - mem_en=1, mem_wr=0 in the first RD_WAIT cycle only; the wait counter clears.
  - When mem_data_valid=1 in RD_WAIT, capture mem_rdata. Next cycle: wb_valid=1, wb_data=captured value, state IDLE.
- On accept of SW: latch addr and wdata, then go to WR_WAIT.
  - mem_en=1, mem_wr=1 in the first WR_WAIT cycle only.
  - After MEM_LATENCY cycles in WR_WAIT, go to IDLE with wb_valid=1 and wb_wr_en=0.
- Load timeout: if the counter reaches TIMEOUT in RD_WAIT without valid data:
  - set err_timeout (sticky until rst), go to IDLE, no wb_valid.
  - If mem_data_valid arrives in the same cycle the counter reaches TIMEOUT, the data is used and no error is raised.
- mem_data_valid is ignored in IDLE and WR_WAIT.
- mem_addr and mem_wdata hold their latched values until the next accept.
- wb_data, wb_dst_reg and wb_wr_en hold their last values when wb_valid=0.
- Reset: all outputs 0, state IDLE, counter 0, err_timeout 0. Reset mid-access abandons the access with no write-back. Late memory data arriving after reset is ignored.
- Counter width is $clog2(TIMEOUT+1) and saturates at TIMEOUT.

## Timing
- Accept edge at the end of cycle T.
- Non-memory op: wb_valid in T+1; stall stays 0, so back-to-back accepts are allowed.
- LW: mem_en in T+1. If data is valid in cycle D, wb_valid is in D+1, and stall is 1 from T+1 through D.
- SW: mem_en in T+1, stall 1 for cycles T+1..T+MEM_LATENCY, wb_valid in T+MEM_LATENCY+1.
- A new ex_valid may be accepted at the end of any cycle in which wb_valid=1.
- No combinational path from ex_* to any output.

## Structure
- Shared package wisc_pkg holds:
  - opcode constants OP_LW, OP_SW;
  - the state enum mem_state_t {IDLE, RD_WAIT, WR_WAIT};
  - the 16-bit word type.
- One sub-module, mem_wait_counter: clear, enable, saturating count, and compare outputs at MEM_LATENCY and TIMEOUT.

## Test plan
- Reset, then ex_valid with opcode 0000, alu_out 16'h1234, dst 5, wr_en 1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_dst_reg=5, stall=0.
- LW with alu_out 16'h0041; memory returns 16'hBEEF 3 cycles after the request -> mem_addr=16'h0040, mem_en pulse exactly one cycle, stall=1 for 3 cycles, wb_data=16'hBEEF.
- SW with alu_out 16'h0010, store_data 16'hA5A5, MEM_LATENCY=4 -> mem_wr=1 with mem_en for one cycle, stall=1 for 4 cycles, wb_valid with wb_wr_en=0; ex_valid pulses during the stall are ignored.
- LW with memory never responding, TIMEOUT=16 -> err_timeout=1 after 16 wait cycles, no wb_valid, stall=0, next op accepted normally.
- LW with rst asserted mid-RD_WAIT, then mem_data_valid after reset -> all outputs 0, no wb_valid, state IDLE.
- Alternate ADD/LW/ADD back-to-back -> write-backs in program order, each ADD retiring in the cycle after its accept.
